// File: rtl/fp8_pkg.sv
// Shared FP8 definitions: 1 sign, 3 exponent (bias 3), 4 fraction with hidden leading 1.
package fp8_pkg;

  typedef struct packed {
    logic       sign;
    logic [2:0] exp;
    logic [3:0] frac;
  } fp8_t;

  localparam int         FP8_BIAS        = 3;
  localparam logic [2:0] FP8_EXP_SPECIAL = 3'd7;
  localparam logic [7:0] FP8_ZERO        = 8'h00;
  localparam logic [6:0] FP8_SAT_MAG     = 7'h6F;

  typedef enum logic {ACC, HOLD} state_t;

endpackage

// File: rtl/fp8_dot_accumulator_fp8_add.sv
// Combinational FP8 adder: align the smaller operand by truncating shift, add/subtract, renormalise.
// Overflow returns the raw exponent-7 pattern (or the exponent-7 operand) with add_ovf set.
module fp8_add
  import fp8_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum,
  output logic       add_ovf
);

  fp8_t       l, s;
  logic [2:0] d;
  logic [4:0] ml, ms, diff, norm;
  logic [5:0] s6;
  logic [2:0] shift;
  logic [3:0] e;
  logic       special;

  always_comb begin
    l = a;
    s = b;
    if (a[6:0] < b[6:0]) begin
      l = b;
      s = a;
    end
    d    = l.exp - s.exp;
    ml   = {1'b1, l.frac};
    ms   = (d >= 3'd5) ? 5'd0 : ({1'b1, s.frac} >> d);
    s6   = {1'b0, ml} + {1'b0, ms};
    diff = ml - ms;
    casez (diff)
      5'b1????: shift = 3'd0;
      5'b01???: shift = 3'd1;
      5'b001??: shift = 3'd2;
      5'b0001?: shift = 3'd3;
      default:  shift = 3'd4;
    endcase
    norm    = diff << shift;
    special = (a[6:4] == FP8_EXP_SPECIAL) || (b[6:4] == FP8_EXP_SPECIAL);
    e       = 4'd0;
    sum     = FP8_ZERO;

    if (l.sign == s.sign) begin
      if (s6[5]) begin
        e   = {1'b0, l.exp} + 4'd1;
        sum = {l.sign, e[2:0], s6[4:1]};
      end else begin
        e   = {1'b0, l.exp};
        sum = {l.sign, e[2:0], s6[3:0]};
      end
    end else if (diff != 5'd0 && {1'b0, l.exp} >= {1'b0, shift}) begin
      e   = {1'b0, l.exp} - {1'b0, shift};
      sum = {l.sign, e[2:0], norm[3:0]};
    end

    // Zero operands pass the other through untouched; an exponent-7 operand is always the larger one.
    add_ovf = special || (e >= 4'd7 && a[6:0] != 7'd0 && b[6:0] != 7'd0);
    if (a[6:0] == 7'd0)
      sum = b;
    else if (b[6:0] == 7'd0)
      sum = a;
    else if (special)
      sum = l;
  end

endmodule

// File: rtl/fp8_dot_accumulator.sv
// Sums K_LEN FP8 products into one result held until out_ready; first overflow freezes the accumulator.
// FP_ACC_SAT_EN: overflow loads the saturated magnitude 0x6F instead of the raw overflow pattern.
module fp8_dot_accumulator
  import fp8_pkg::*;
#(
  parameter int K_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_ovf,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_ovf
);

  localparam int CNT_W = $clog2(K_LEN + 1);

  state_t           state;
  logic [7:0]       acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf, frozen;
  logic [7:0]       add_sum, ovf_val, acc_next;
  logic             add_ovf, ovf_next;

  fp8_add u_add (
    .a       (acc),
    .b       (in_data),
    .sum     (add_sum),
    .add_ovf (add_ovf)
  );

  assign in_ready = (state == ACC);

`ifdef FP_ACC_SAT_EN
  assign ovf_val = {add_sum[7], FP8_SAT_MAG};
`else
  assign ovf_val = add_sum;
`endif

  always_comb begin
    acc_next = acc;
    if (!frozen)
      acc_next = add_ovf ? ovf_val : add_sum;
    ovf_next = ovf | in_ovf | (!frozen & add_ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      acc       <= FP8_ZERO;
      cnt       <= '0;
      ovf       <= 1'b0;
      frozen    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= FP8_ZERO;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            acc    <= acc_next;
            cnt    <= cnt + CNT_W'(1);
            ovf    <= ovf_next;
            frozen <= frozen | add_ovf;
            if (cnt == CNT_W'(K_LEN - 1)) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_data  <= acc_next;
              out_ovf   <= ovf_next;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACC;
            acc       <= FP8_ZERO;
            cnt       <= '0;
            ovf       <= 1'b0;
            frozen    <= 1'b0;
            out_valid <= 1'b0;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_fp8_dot_accumulator.sv
// Directed bench for fp8_dot_accumulator: integer-valued FP8 reference model plus literal group results.
module tb_fp8_dot_accumulator;

  localparam int K = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_ovf, out_valid, out_ready, out_ovf;
  logic [7:0] in_data, out_data;

  int n_checks = 0;
  int n_fail   = 0;

  fp8_dot_accumulator #(.K_LEN(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ovf    (in_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Values as integers in units of 2^-7: magnitude = (16+frac) << exp.
  function automatic logic [8:0] m_add(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] l, s;
    int vl, vs, r, p, e;
    if (a[6:0] >= b[6:0]) begin l = a; s = b; end
    else begin l = b; s = a; end
    if (a[6:4] == 3'd7 || b[6:4] == 3'd7) return {1'b1, l};
    if (a[6:0] == 7'd0) return {1'b0, b};
    if (b[6:0] == 7'd0) return {1'b0, a};
    vl = (16 + int'(l[3:0])) << l[6:4];
    vs = (((16 + int'(s[3:0])) << s[6:4]) >> l[6:4]) << l[6:4];
    r  = (l[7] == s[7]) ? vl + vs : vl - vs;
    if (r == 0) return 9'h000;
    p = 0;
    for (int i = 0; i < 12; i++) if ((r >> i) != 0) p = i;
    e = p - 4;
    if (e < 0) return 9'h000;
    return {(e >= 7), l[7], 3'(e), 4'((r >> e) - 16)};
  endfunction

  // Reference model and per-cycle comparison.
  logic [7:0] m_acc, m_res;
  logic       m_ovf, m_frozen, m_hold, m_res_ovf;
  int         m_cnt;
  logic [8:0] m_r;

  initial begin
    m_acc = 0; m_res = 0; m_ovf = 0; m_frozen = 0; m_hold = 0; m_res_ovf = 0; m_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_acc = 0; m_ovf = 0; m_frozen = 0; m_hold = 0; m_cnt = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ovf", out_ovf, 0);
      end else begin
        chk("cyc_out_valid", out_valid, m_hold);
        chk("cyc_in_ready", in_ready, !m_hold);
        if (m_hold) begin
          chk("cyc_out_data", out_data, m_res);
          chk("cyc_out_ovf", out_ovf, m_res_ovf);
          if (out_ready) begin
            m_hold = 0; m_acc = 0; m_ovf = 0; m_frozen = 0; m_cnt = 0;
          end
        end else if (in_valid) begin
          m_ovf = m_ovf | in_ovf;
          if (!m_frozen) begin
            m_r = m_add(m_acc, in_data);
            if (m_r[8]) begin
`ifdef FP_ACC_SAT_EN
              m_acc = {m_r[7], 7'h6F};
`else
              m_acc = m_r[7:0];
`endif
              m_frozen = 1; m_ovf = 1;
            end else begin
              m_acc = m_r[7:0];
            end
          end
          m_cnt++;
          if (m_cnt == K) begin
            m_hold = 1; m_res = m_acc; m_res_ovf = m_ovf;
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic o);
    int tmo;
    in_valid = 1; in_data = d; in_ovf = o;
    tmo = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      tmo++;
      if (tmo > 50) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    in_ovf = 0;
  endtask

  task automatic run_group(input string name, input logic [31:0] v, input logic [3:0] om,
                           input logic [7:0] ed, input logic eo);
    for (int i = 0; i < K; i++) send(v[31-8*i -: 8], om[i]);
    in_valid = 0;
    @(negedge clk);
    chk({name, "_vld"}, out_valid, 1);
    chk({name, "_data"}, out_data, ed);
    chk({name, "_ovf"}, out_ovf, eo);
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 0; in_valid = 0; in_data = 0; in_ovf = 0; out_ready = 1;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    chk("model_1p1", m_add(8'h30, 8'h30), 9'h040);
    chk("model_cancel", m_add(8'h38, 8'hB8), 9'h000);
    chk("model_trunc", m_add(8'h34, 8'h0F), 9'h037);
    chk("model_ovf", m_add(8'h60, 8'h60), 9'h170);
    chk("model_negsub", m_add(8'hC0, 8'h30), 9'h0B0);

    run_group("ones", 32'h30303030, 4'b0000, 8'h50, 0);
    run_group("cancel", 32'h38B83030, 4'b0000, 8'h40, 0);
    run_group("trunc", 32'h30100F00, 4'b0000, 8'h37, 0);
    run_group("neg", 32'hB0B030C0, 4'b0000, 8'hC8, 0);
`ifdef FP_ACC_SAT_EN
    run_group("big", 32'h60606060, 4'b0000, 8'h6F, 1);
    run_group("exp7", 32'h30703030, 4'b0000, 8'h6F, 1);
`else
    run_group("big", 32'h60606060, 4'b0000, 8'h70, 1);
    run_group("exp7", 32'h30703030, 4'b0000, 8'h70, 1);
`endif
    run_group("inovf", 32'h30303030, 4'b0100, 8'h50, 1);

    // Consumer stalls: result must hold and no term may be taken.
    out_ready = 0;
    run_group("stall", 32'h30303030, 4'b0000, 8'h50, 0);
    in_valid = 1; in_data = 8'h30;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_data", out_data, 8'h50);
      chk("stall_vld", out_valid, 1);
    end
    @(posedge clk); #1;
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    run_group("after_stall", 32'h30100F00, 4'b0000, 8'h37, 0);

    // Asynchronous reset while holding a result.
    out_ready = 0;
    run_group("pre_rst", 32'h30303030, 4'b0000, 8'h50, 0);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1; out_ready = 1;

    // Reset after two accepted terms discards the partial group.
    send(8'h30, 1);
    send(8'h60, 0);
    in_valid = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_out_ovf", out_ovf, 0);
    @(posedge clk); #1;
    rst_n = 1;
    run_group("post_rst", 32'h30303030, 4'b0000, 8'h50, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
